// File: rtl/vec_ctrl_pkg.sv
// Shared definitions for the vector-op controller slice.
//   - MODE_W and the operation mode codes (SCALE, DOT, ACCUM, reserved)
//   - state encoding constants and the FSM state type
//   - uses_acc(): true for modes that drive the accumulator
// No ports; imported by the interface, the step counter's user and the top.
package vec_ctrl_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_SCALE = 2'b00;
  localparam logic [MODE_W-1:0] MODE_DOT   = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ACCUM = 2'b10;
  localparam logic [MODE_W-1:0] MODE_RSVD  = 2'b11;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_LOAD_ENC  = 3'd1;
  localparam logic [2:0] ST_RUN_ENC   = 3'd2;
  localparam logic [2:0] ST_DRAIN_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_LOAD  = ST_LOAD_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_DRAIN = ST_DRAIN_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_t;

  function automatic logic uses_acc(input logic [MODE_W-1:0] m);
    return (m == MODE_DOT) || (m == MODE_ACCUM);
  endfunction

endpackage

// File: rtl/vector_op_controller_if.sv
// Handshake/strobe bundle between an operation requester and the
// vector-op controller.
//   master : drives start, mode, abort (and stall when VOC_STALL_EN is
//            defined); observes the strobes and status.
//   slave  : the controller; the reverse directions.
// Signals:
//   start, mode[MODE_W], abort, stall (VOC_STALL_EN only)
//   load, shift, acc_clr, acc_en, capture, busy, done, err
interface vector_op_controller_if;
  import vec_ctrl_pkg::*;

  logic              start;
  logic [MODE_W-1:0] mode;
  logic              abort;
`ifdef VOC_STALL_EN
  logic              stall;
`endif
  logic              load;
  logic              shift;
  logic              acc_clr;
  logic              acc_en;
  logic              capture;
  logic              busy;
  logic              done;
  logic              err;

`ifdef VOC_STALL_EN
  modport master (
    output start, mode, abort, stall,
    input  load, shift, acc_clr, acc_en, capture, busy, done, err
  );
  modport slave (
    input  start, mode, abort, stall,
    output load, shift, acc_clr, acc_en, capture, busy, done, err
  );
`else
  modport master (
    output start, mode, abort,
    input  load, shift, acc_clr, acc_en, capture, busy, done, err
  );
  modport slave (
    input  start, mode, abort,
    output load, shift, acc_clr, acc_en, capture, busy, done, err
  );
`endif

endinterface

// File: rtl/voc_step_counter.sv
// Step counter shared by the RUN and DRAIN phases.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset (count -> 0)
//   clr    in  synchronous clear (wins over en)
//   en     in  count enable
//   limit  in  runtime terminal value
//   tc     out count equals limit
// The compare is on the current count, so the owner can clear on tc
// instead of incrementing and the count never wraps.
module voc_step_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign tc = (cnt_reg == limit);

endmodule

// File: rtl/vector_op_controller.sv
// Sequencer for the shift-register vector datapath (SCALE, DOT, ACCUM).
// Flow: IDLE -> LOAD -> RUN (M cycles) -> DRAIN (LAT cycles) -> DONE,
// with back-to-back restart from DONE, abort to IDLE from any busy state
// and the reserved mode reported as err straight after LOAD.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave modport of vector_op_controller_if
//            in : start, mode, abort, stall (VOC_STALL_EN only)
//            out: load, shift, acc_clr, acc_en, capture, busy, done, err
// Parameters: M (vector length, >=1), LAT (pipeline latency, >=0),
//   CNT_W (step counter width, 2**CNT_W > max(M, LAT)).
// Optional feature macro: VOC_STALL_EN adds the stall input that freezes
//   RUN/DRAIN; without it the controller behaves as if stall were 0.
module vector_op_controller
  import vec_ctrl_pkg::*;
#(
  parameter int M     = 4,
  parameter int LAT   = 2,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  vector_op_controller_if.slave   bus
);

  localparam logic [CNT_W-1:0] RUN_LIMIT   = CNT_W'(M - 1);
  // DRAIN is never entered when LAT==0, so its limit is then irrelevant.
  localparam logic [CNT_W-1:0] DRAIN_LIMIT = (LAT > 0) ? CNT_W'(LAT - 1) : '0;

  state_t            state_reg, state_next;
  logic [MODE_W-1:0] mode_reg, mode_next;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]  cnt_limit;
  logic              stall_eff;

`ifdef VOC_STALL_EN
  assign stall_eff = bus.stall;
`else
  assign stall_eff = 1'b0;
`endif

  assign cnt_limit = (state_reg == ST_DRAIN) ? DRAIN_LIMIT : RUN_LIMIT;

  voc_step_counter #(
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_limit),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      mode_reg  <= MODE_SCALE;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    if (bus.abort && (state_reg != ST_IDLE)) begin
      // Abort overrides start, stall and terminal count.
      state_next = ST_IDLE;
      cnt_clr    = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            mode_next  = bus.mode;
            state_next = ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt_clr    = 1'b1;
          state_next = (mode_reg == MODE_RSVD) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (!stall_eff) begin
            if (cnt_tc) begin
              cnt_clr    = 1'b1;
              state_next = (LAT > 0) ? ST_DRAIN : ST_DONE;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!stall_eff) begin
            if (cnt_tc) begin
              cnt_clr    = 1'b1;
              state_next = ST_DONE;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        ST_DONE: begin
          cnt_clr = 1'b1;
          if (bus.start) begin
            mode_next  = bus.mode;
            state_next = ST_LOAD;
          end else begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_clr    = 1'b1;
        end
      endcase
    end
  end

  // Strobes decode the registered state and mode; stall only masks the
  // datapath advance strobes while frozen.
  always_comb begin
    bus.load    = (state_reg == ST_LOAD);
    bus.acc_clr = (state_reg == ST_LOAD) && (mode_reg == MODE_DOT);
    bus.shift   = !stall_eff &&
                  ((state_reg == ST_RUN) ||
                   ((state_reg == ST_DRAIN) && (mode_reg == MODE_SCALE)));
    bus.acc_en  = !stall_eff && (state_reg == ST_RUN) && uses_acc(mode_reg);
    bus.capture = (state_reg == ST_DONE) && uses_acc(mode_reg);
    bus.done    = (state_reg == ST_DONE);
    bus.err     = (state_reg == ST_DONE) && (mode_reg == MODE_RSVD);
    bus.busy    = (state_reg != ST_IDLE);
  end

endmodule

// File: tb/tb_vector_op_controller.sv
// Self-checking bench for vector_op_controller (M=4, LAT=2).
// The reference model tracks only "operation active" plus the number of
// cycles elapsed since LOAD; expected strobes come from which window of
// that elapsed time the operation is in.
module tb_vector_op_controller;
  import vec_ctrl_pkg::*;

  localparam int M     = 4;
  localparam int LAT   = 2;
  localparam int CNT_W = 8;
`ifdef VOC_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vector_op_controller_if bus ();

  vector_op_controller #(
    .M     (M),
    .LAT   (LAT),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model
  bit         m_active = 1'b0;
  int         m_t      = 0;
  logic [1:0] m_mode   = 2'b00;

  // observation statistics
  int n_done, n_load, n_shift, n_acc_en, n_clr, n_cap, n_err, n_busy;
  int done_at, load_at, clr_at;
  int c0;

  function automatic int done_time(input logic [1:0] md);
    return (md == MODE_RSVD) ? 1 : (M + LAT + 1);
  endfunction

  task automatic cmp(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %b expected %b cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_done = 0; n_load = 0; n_shift = 0; n_acc_en = 0; n_clr = 0;
    n_cap = 0; n_err = 0; n_busy = 0;
    done_at = -1; load_at = -1; clr_at = -1;
  endtask

  task automatic chk_zero();
    cmp("rst_load",    bus.load,    1'b0);
    cmp("rst_shift",   bus.shift,   1'b0);
    cmp("rst_acc_clr", bus.acc_clr, 1'b0);
    cmp("rst_acc_en",  bus.acc_en,  1'b0);
    cmp("rst_capture", bus.capture, 1'b0);
    cmp("rst_busy",    bus.busy,    1'b0);
    cmp("rst_done",    bus.done,    1'b0);
    cmp("rst_err",     bus.err,     1'b0);
  endtask

  // One clock cycle: apply inputs, compare every output against the
  // model, then advance the model on the rising edge.
  task automatic step(input logic s, input logic [1:0] md, input logic ab, input logic st);
    logic st_eff, ld, run, drain, dn, acc;
    bus.start = s;
    bus.mode  = md;
    bus.abort = ab;
`ifdef VOC_STALL_EN
    bus.stall = st;
`endif
    st_eff = st & STALL_ON;
    #1;
    ld    = m_active && (m_t == 0);
    run   = m_active && (m_mode != MODE_RSVD) && (m_t >= 1) && (m_t <= M);
    drain = m_active && (m_mode != MODE_RSVD) && (m_t > M) && (m_t <= M + LAT);
    dn    = m_active && (m_t == done_time(m_mode));
    acc   = (m_mode == MODE_DOT) || (m_mode == MODE_ACCUM);
    cmp("load",    bus.load,    ld);
    cmp("shift",   bus.shift,   !st_eff && (run || (drain && m_mode == MODE_SCALE)));
    cmp("acc_clr", bus.acc_clr, ld && (m_mode == MODE_DOT));
    cmp("acc_en",  bus.acc_en,  !st_eff && run && acc);
    cmp("capture", bus.capture, dn && acc);
    cmp("busy",    bus.busy,    m_active);
    cmp("done",    bus.done,    dn);
    cmp("err",     bus.err,     dn && (m_mode == MODE_RSVD));
    if (bus.done === 1'b1)    begin n_done++; done_at = cyc; end
    if (bus.load === 1'b1)    begin n_load++; load_at = cyc; end
    if (bus.acc_clr === 1'b1) begin n_clr++;  clr_at  = cyc; end
    if (bus.shift === 1'b1)   n_shift++;
    if (bus.acc_en === 1'b1)  n_acc_en++;
    if (bus.capture === 1'b1) n_cap++;
    if (bus.err === 1'b1)     n_err++;
    if (bus.busy === 1'b1)    n_busy++;
    @(posedge clk);
    if (m_active && ab) begin
      m_active = 1'b0;
    end else if (!m_active || dn) begin
      if (s) begin
        m_active = 1'b1;
        m_t      = 0;
        m_mode   = md;
      end else begin
        m_active = 1'b0;
      end
    end else if (!(st_eff && (run || drain))) begin
      m_t++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    bus.abort = 1'b0;
`ifdef VOC_STALL_EN
    bus.stall = 1'b0;
`endif
    clear_stats();

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk_zero();
    reset = 1'b1;
    idle(2);

    // SCALE: load at +1, shift +2..+7, done at +8
    clear_stats(); c0 = cyc;
    step(1'b1, MODE_SCALE, 1'b0, 1'b0);
    idle(10);
    cmp_int("scale_load_at", load_at - c0, 1);
    cmp_int("scale_done_at", done_at - c0, M + LAT + 2);
    cmp_int("scale_shifts",  n_shift, M + LAT);
    cmp_int("scale_capture", n_cap, 0);
    cmp_int("scale_err",     n_err, 0);
    $display("op SCALE done_at=+%0d shifts=%0d", done_at - c0, n_shift);

    // DOT: acc_clr at +1, shift/acc_en for M cycles, capture with done
    clear_stats(); c0 = cyc;
    step(1'b1, MODE_DOT, 1'b0, 1'b0);
    idle(10);
    cmp_int("dot_clr_at",   clr_at - c0, 1);
    cmp_int("dot_shifts",   n_shift, M);
    cmp_int("dot_acc_en",   n_acc_en, M);
    cmp_int("dot_done_at",  done_at - c0, M + LAT + 2);
    cmp_int("dot_capture",  n_cap, 1);
    $display("op DOT done_at=+%0d acc_en=%0d", done_at - c0, n_acc_en);

    // ACCUM back-to-back with start held through DONE
    clear_stats(); c0 = cyc;
    for (int i = 0; i <= M + LAT + 2; i++) step(1'b1, MODE_ACCUM, 1'b0, 1'b0);
    idle(12);
    cmp_int("b2b_loads",     n_load, 2);
    cmp_int("b2b_load2_at",  load_at - c0, M + LAT + 3);
    cmp_int("b2b_done2_at",  done_at - c0, 2 * (M + LAT + 2));
    cmp_int("b2b_busy",      n_busy, 2 * (M + LAT + 2));
    cmp_int("b2b_acc_clr",   n_clr, 0);
    cmp_int("b2b_capture",   n_cap, 2);
    $display("op ACCUMx2 done2_at=+%0d busy_cycles=%0d", done_at - c0, n_busy);

    // reserved mode: done+err right after load, no shifts
    clear_stats(); c0 = cyc;
    step(1'b1, MODE_RSVD, 1'b0, 1'b0);
    idle(4);
    cmp_int("rsvd_done_at", done_at - c0, 2);
    cmp_int("rsvd_err",     n_err, 1);
    cmp_int("rsvd_shift",   n_shift, 0);
    $display("op RSVD done_at=+%0d err=%0d", done_at - c0, n_err);

    // asynchronous reset in RUN cycle 4
    clear_stats(); c0 = cyc;
    step(1'b1, MODE_DOT, 1'b0, 1'b0);
    idle(3);
    cmp("pre_rst_shift", bus.shift, 1'b1);
    reset = 1'b0;
    #1;
    chk_zero();
    m_active = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b1;
    idle(4);
    cmp_int("rst_no_done", n_done, 0);
    $display("op DOT reset at +4 done=%0d", n_done);

    // abort in DRAIN
    clear_stats(); c0 = cyc;
    step(1'b1, MODE_SCALE, 1'b0, 1'b0);
    idle(M + 1);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    cmp("abort_busy", bus.busy, 1'b0);
    idle(4);
    cmp_int("abort_no_done", n_done, 0);
    $display("op SCALE abort in drain done=%0d", n_done);

`ifdef VOC_STALL_EN
    // stall during RUN cycles 3..4 delays done to +10
    clear_stats(); c0 = cyc;
    step(1'b1, MODE_SCALE, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    idle(8);
    cmp_int("stall_done_at", done_at - c0, M + LAT + 4);
    cmp_int("stall_shifts",  n_shift, M + LAT);
    $display("op SCALE stalled done_at=+%0d", done_at - c0);

    // abort while stalled
    clear_stats(); c0 = cyc;
    step(1'b1, MODE_DOT, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 2'b00, 1'b1, 1'b1);
    cmp("stall_abort_busy", bus.busy, 1'b0);
    idle(3);
    cmp_int("stall_abort_no_done", n_done, 0);
    $display("op DOT abort during stall done=%0d", n_done);
`endif

    // randomized traffic against the model
    clear_stats();
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 9) < 3),
           2'($urandom_range(0, 3)),
           logic'($urandom_range(0, 99) < 3),
           logic'($urandom_range(0, 9) < 2));
    end
    $display("random phase ops_done=%0d", n_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
